// File: rtl/neuron_accumulator.sv
// neuron_accumulator: sums NUM_TERMS signed terms onto a signed bias, with valid/ready on both sides.
// Define NEURON_ACC_SATURATE_EN to clamp the accumulator on signed overflow instead of wrapping.
module neuron_accumulator #(
    parameter int ACC_W     = 17,
    parameter int IN_W      = 8,
    parameter int NUM_TERMS = 4,
    parameter int CNT_W     = $clog2(NUM_TERMS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ACC_W-1:0] bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_carry,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t           r_state;
    state_t           w_next;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ovf;
    logic [ACC_W:0]   w_full;
    logic             w_step_ovf;
    logic             w_beat;
    logic             w_last;

    // One extra bit of headroom: the top two bits of the sum disagree exactly on signed overflow.
    assign w_full     = {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data} + {r_acc[ACC_W-1], r_acc};
    assign w_step_ovf = w_full[ACC_W] ^ w_full[ACC_W-1];
    assign w_beat     = (r_state == ST_ACCUM) && in_valid;
    assign w_last     = (r_cnt == CNT_W'(NUM_TERMS - 1));

    // Next accumulator value for an accepted beat (wrap or clamp on overflow)
    always_comb begin
        w_acc_next = w_full[ACC_W-1:0];
`ifdef NEURON_ACC_SATURATE_EN
        if (w_step_ovf) begin
            if (w_full[ACC_W]) begin
                w_acc_next = SAT_MIN;
            end else begin
                w_acc_next = SAT_MAX;
            end
        end else begin
            w_acc_next = w_full[ACC_W-1:0];
        end
`else
        if (w_step_ovf) begin
            w_acc_next = w_full[ACC_W-1:0];
        end else begin
            w_acc_next = w_full[ACC_W-1:0];
        end
`endif
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state and handshake outputs, decoded from the state register so reset clears them at once
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_ACCUM;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid && w_last) begin
                    w_next = ST_DONE;
                end else begin
                    w_next = ST_ACCUM;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Accumulator datapath: load bias on start, add one term per accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= {ACC_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_acc   <= bias;
            r_cnt   <= {CNT_W{1'b0}};
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_beat) begin
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_full[ACC_W];
            r_ovf   <= r_ovf | w_step_ovf;
        end else begin
            r_acc   <= r_acc;
            r_cnt   <= r_cnt;
            r_carry <= r_carry;
            r_ovf   <= r_ovf;
        end
    end

    assign out_sum   = r_acc;
    assign out_carry = r_carry;
    assign out_ovf   = r_ovf;

endmodule
